// File: rtl/caf_sequencer.sv
// Control FSM for the CAF core: captures one frame of stream words, then sweeps (freq, lag, k)
// issuing paired reference/capture read addresses. Optional abort input: `define CAF_SEQ_ABORT_EN.
module caf_sequencer #(
    parameter int REF_INDEX_BITS = 5,
    parameter int CAP_INDEX_BITS = 6,
    parameter int FREQ_BINS      = 4,
    parameter int FREQ_BITS      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef CAF_SEQ_ABORT_EN
    input  logic                      abort,
`endif
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic                      m_axis_tvalid,
    output logic                      s_axis_tready,
    output logic                      cap_wvalid,
    input  logic                      cap_wready,
    output logic [CAP_INDEX_BITS-1:0] cap_waddr,
    output logic                      rd_valid,
    input  logic                      ref_rready,
    input  logic                      cap_rready,
    output logic [REF_INDEX_BITS-1:0] ref_raddr,
    output logic [CAP_INDEX_BITS-1:0] cap_raddr,
    output logic [FREQ_BITS-1:0]      freq_idx,
    output logic [CAP_INDEX_BITS-1:0] lag_idx,
    output logic                      rd_last
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAPTURE   = 2'd1,
        ST_CORRELATE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam logic [REF_INDEX_BITS-1:0] K_MAX    = '1;
    localparam logic [CAP_INDEX_BITS-1:0] WADDR_MAX = '1;
    // Last lag keeps lag+k inside the capture buffer, so cap_raddr never wraps.
    localparam logic [CAP_INDEX_BITS-1:0] LAG_MAX  =
        CAP_INDEX_BITS'((2 ** CAP_INDEX_BITS) - (2 ** REF_INDEX_BITS));
    localparam logic [FREQ_BITS-1:0]      FREQ_MAX = FREQ_BITS'(FREQ_BINS - 1);

    state_t                      state_q, state_d;
    logic [CAP_INDEX_BITS-1:0]   waddr_q, waddr_d;
    logic [REF_INDEX_BITS-1:0]   k_q, k_d;
    logic [CAP_INDEX_BITS-1:0]   lag_q, lag_d;
    logic [CAP_INDEX_BITS-1:0]   craddr_q, craddr_d;
    logic [FREQ_BITS-1:0]        freq_q, freq_d;
    logic                        abort_s;
    logic                        wr_fire_s;
    logic                        rd_fire_s;

`ifdef CAF_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign busy          = (state_q == ST_CAPTURE) || (state_q == ST_CORRELATE);
    assign done          = (state_q == ST_DONE);
    assign s_axis_tready = (state_q == ST_CAPTURE) && cap_wready;
    assign cap_wvalid    = m_axis_tvalid && s_axis_tready;
    assign rd_valid      = (state_q == ST_CORRELATE);
    assign wr_fire_s     = cap_wvalid;
    assign rd_fire_s     = rd_valid && ref_rready && cap_rready;
    assign cap_waddr     = waddr_q;
    assign ref_raddr     = k_q;
    assign cap_raddr     = craddr_q;
    assign lag_idx       = lag_q;
    assign freq_idx      = freq_q;
    assign rd_last       = rd_valid && (k_q == K_MAX);

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            waddr_q  <= '0;
            k_q      <= '0;
            lag_q    <= '0;
            craddr_q <= '0;
            freq_q   <= '0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            k_q      <= k_d;
            lag_q    <= lag_d;
            craddr_q <= craddr_d;
            freq_q   <= freq_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        k_d      = k_q;
        lag_d    = lag_q;
        craddr_d = craddr_q;
        freq_d   = freq_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CAPTURE;
                    waddr_d  = '0;
                    k_d      = '0;
                    lag_d    = '0;
                    craddr_d = '0;
                    freq_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    waddr_d = '0;
                end else if (wr_fire_s) begin
                    if (waddr_q == WADDR_MAX) begin
                        waddr_d = '0;
                        state_d = ST_CORRELATE;
                    end else begin
                        waddr_d = waddr_q + CAP_INDEX_BITS'(1);
                    end
                end else begin
                    waddr_d = waddr_q;
                end
            end
            ST_CORRELATE: begin
                if (abort_s) begin
                    state_d  = ST_IDLE;
                    k_d      = '0;
                    lag_d    = '0;
                    craddr_d = '0;
                    freq_d   = '0;
                end else if (rd_fire_s) begin
                    if (k_q == K_MAX) begin
                        k_d = '0;
                        if (lag_q == LAG_MAX) begin
                            lag_d    = '0;
                            craddr_d = '0;
                            if (freq_q == FREQ_MAX) begin
                                freq_d  = '0;
                                state_d = ST_DONE;
                            end else begin
                                freq_d = freq_q + FREQ_BITS'(1);
                            end
                        end else begin
                            lag_d    = lag_q + CAP_INDEX_BITS'(1);
                            craddr_d = lag_q + CAP_INDEX_BITS'(1);
                        end
                    end else begin
                        k_d      = k_q + REF_INDEX_BITS'(1);
                        craddr_d = craddr_q + CAP_INDEX_BITS'(1);
                    end
                end else begin
                    state_d = ST_CORRELATE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_caf_sequencer.sv
// Directed bench for caf_sequencer with a scoreboard of expected write addresses and read tuples.
module tb_caf_sequencer;

    localparam int RB = 2;
    localparam int CB = 3;
    localparam int FB = 2;
    localparam int FW = 1;
    localparam int NLAG = 5;
    localparam int NREAD = 40;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          m_axis_tvalid;
    logic          s_axis_tready;
    logic          cap_wvalid;
    logic          cap_wready;
    logic [CB-1:0] cap_waddr;
    logic          rd_valid;
    logic          ref_rready;
    logic          cap_rready;
    logic [RB-1:0] ref_raddr;
    logic [CB-1:0] cap_raddr;
    logic [FW-1:0] freq_idx;
    logic [CB-1:0] lag_idx;
    logic          rd_last;
`ifdef CAF_SEQ_ABORT_EN
    logic          abort;
`endif

    int passes = 0;
    int checks = 0;

    logic [9:0] exp_q[$];
    logic [2:0] wexp_q[$];

    caf_sequencer #(
        .REF_INDEX_BITS(RB),
        .CAP_INDEX_BITS(CB),
        .FREQ_BINS     (FB),
        .FREQ_BITS     (FW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef CAF_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .start        (start),
        .busy         (busy),
        .done         (done),
        .m_axis_tvalid(m_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .cap_wvalid   (cap_wvalid),
        .cap_wready   (cap_wready),
        .cap_waddr    (cap_waddr),
        .rd_valid     (rd_valid),
        .ref_rready   (ref_rready),
        .cap_rready   (cap_rready),
        .ref_raddr    (ref_raddr),
        .cap_raddr    (cap_raddr),
        .freq_idx     (freq_idx),
        .lag_idx      (lag_idx),
        .rd_last      (rd_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pack(input logic [0:0] f, input logic [2:0] l,
                                        input logic [1:0] k, input logic [2:0] c,
                                        input logic last);
        return {f, l, k, c, last};
    endfunction

    function automatic logic [9:0] observed();
        return pack(freq_idx, lag_idx, ref_raddr, cap_raddr, rd_last);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rdv"}, 32'(rd_valid), 32'd0);
        chk({tag, "_trdy"}, 32'(s_axis_tready), 32'd0);
        chk({tag, "_addrs"}, 32'({cap_waddr, ref_raddr, cap_raddr, freq_idx, lag_idx, rd_last}), 32'd0);
    endtask

    // Begins and ends just after a falling edge.
    task automatic start_run();
        start = 1'b1;
        #1;
        chk("start_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic capture(input bit stall);
        int writes = 0;
        int stalled = 0;
        int cyc = 0;
        for (int i = 0; i < 8; i++) wexp_q.push_back(3'(i));
        while (writes < 8 && cyc < 60) begin
            m_axis_tvalid = 1'b1;
            if (stall && writes == 3 && stalled < 3) begin
                cap_wready = 1'b0;
                start      = (stalled == 1) ? 1'b1 : 1'b0;
                #1;
                chk("stall_trdy", 32'(s_axis_tready), 32'd0);
                chk("stall_wvalid", 32'(cap_wvalid), 32'd0);
                chk("stall_waddr", 32'(cap_waddr), 32'd3);
                stalled++;
            end else begin
                cap_wready = 1'b1;
                start      = 1'b0;
                #1;
                chk("cap_busy", 32'(busy), 32'd1);
                chk("cap_wvalid", 32'(cap_wvalid), 32'd1);
                chk("cap_waddr", 32'(cap_waddr), 32'(wexp_q.pop_front()));
                writes++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("cap_write_count", 32'(writes), 32'd8);
        start         = 1'b0;
        m_axis_tvalid = 1'b0;
        #1;
        chk("corr_entry_rdv", 32'(rd_valid), 32'd1);
        chk("corr_entry_trdy", 32'(s_axis_tready), 32'd0);
        chk("corr_entry_busy", 32'(busy), 32'd1);
    endtask

    task automatic correlate(input int mode, input int stop_at);
        int fires = 0;
        int cyc = 0;
        exp_q.delete();
        for (int f = 0; f < FB; f++)
            for (int l = 0; l < NLAG; l++)
                for (int k = 0; k < 4; k++)
                    exp_q.push_back(pack(1'(f), 3'(l), 2'(k), 3'(l + k), (k == 3)));
        while (fires < stop_at && cyc < 500) begin
            if (mode == 1) begin
                ref_rready = (cyc % 3 != 1);
                cap_rready = (cyc % 3 != 2);
                start      = (cyc == 5) ? 1'b1 : 1'b0;
            end else begin
                ref_rready = 1'b1;
                cap_rready = 1'b1;
                start      = 1'b0;
            end
            #1;
            chk("rd_valid_high", 32'(rd_valid), 32'd1);
            if (ref_rready && cap_rready) begin
                chk("fire_tuple", 32'(observed()), 32'(exp_q.pop_front()));
                fires++;
            end else begin
                chk("hold_tuple", 32'(observed()), 32'(exp_q[0]));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("fire_count", 32'(fires), 32'(stop_at));
        if (stop_at == NREAD) begin
            #1;
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_rdv", 32'(rd_valid), 32'd0);
            chk("queue_empty", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            #1;
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_after_done", 32'(busy), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        m_axis_tvalid = 1'b0;
        cap_wready    = 1'b0;
        ref_rready    = 1'b0;
        cap_rready    = 1'b0;
`ifdef CAF_SEQ_ABORT_EN
        abort         = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        chk("reset_wvalid", 32'(cap_wvalid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Run 1: clean capture, both readys held high.
        start_run();
        capture(1'b0);
        correlate(0, NREAD);

        // Run 2: capture stall with ignored start, out-of-phase readys and ignored start.
        start_run();
        capture(1'b1);
        correlate(1, NREAD);

        // Run 3: stopped on the 17th fire.
        start_run();
        capture(1'b0);
        correlate(0, 16);
        ref_rready = 1'b1;
        cap_rready = 1'b1;
`ifdef CAF_SEQ_ABORT_EN
        abort = 1'b1;
`else
        rst = 1'b1;
`endif
        #1;
        chk("fire17_tuple", 32'(observed()), 32'(exp_q[0]));
        @(negedge clk);
`ifdef CAF_SEQ_ABORT_EN
        abort = 1'b0;
`else
        rst = 1'b0;
`endif
        ref_rready = 1'b0;
        cap_rready = 1'b0;
        #1;
        check_idle_outputs("stopped");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("no_done_after_stop", 32'(done), 32'd0);
            chk("stay_idle", 32'(busy), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
